// File: rtl/eqed_sig_checker.sv
// eqed_sig_checker: dual-MISR signature checker for E-QED capture windows (optional EQED_SIG_CYCLE_CNT_EN adds cycle stamping)
module eqed_sig_checker #(
  parameter int IN_W = 2,
  parameter int OUT_W = 3,
  parameter int SIG_W = 6,
  parameter logic [SIG_W-1:0] POLY = 6'b110000,
  parameter logic [SIG_W-1:0] SEED = 6'b000001,
  parameter int WINDOW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  in_vec,
  input  logic [OUT_W-1:0] out_vec,
  input  logic [SIG_W-1:0] exp_in_sig,
  input  logic [SIG_W-1:0] exp_out_sig,
  output logic [SIG_W-1:0] in_sig,
  output logic [SIG_W-1:0] out_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail
`ifdef EQED_SIG_CYCLE_CNT_EN
  ,
  output logic [15:0]      cyc_cnt,
  output logic [15:0]      done_cyc
`endif
);
  typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE} state_t;
  localparam logic [7:0] LAST = 8'(WINDOW - 1);
  state_t state;
  logic [7:0] cnt;
  logic [SIG_W-1:0] in_nxt, out_nxt;
  logic match;
  // next MISR values: shift in XOR of tapped bits, then fold in the zero-extended vector
  always_comb begin
    in_nxt = {in_sig[SIG_W-2:0], ^(in_sig & POLY)} ^ SIG_W'(in_vec);
    out_nxt = {out_sig[SIG_W-2:0], ^(out_sig & POLY)} ^ SIG_W'(out_vec);
    match = (in_sig == exp_in_sig) && (out_sig == exp_out_sig);
  end
  // control FSM with registered outputs; abort overrides everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      in_sig <= '0;
      out_sig <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        if (state != IDLE) begin
          pass <= 1'b0;
          fail <= 1'b0;
        end
        busy <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            in_sig <= SEED;
            out_sig <= SEED;
            cnt <= '0;
            pass <= 1'b0;
            fail <= 1'b0;
            busy <= 1'b1;
            state <= CAPTURE;
          end
          CAPTURE: begin
            in_sig <= in_nxt;
            out_sig <= out_nxt;
            cnt <= cnt + 8'd1;
            state <= (cnt == LAST) ? COMPARE : CAPTURE;
          end
          COMPARE: begin
            pass <= match;
            fail <= !match;
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef EQED_SIG_CYCLE_CNT_EN
  // saturating cycle counter and the stamp taken on the edge that raises done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= 16'd1;
      done_cyc <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + {15'd0, ~&cyc_cnt};
      done_cyc <= (state == COMPARE && !abort) ? cyc_cnt : done_cyc;
    end
  end
`endif
endmodule

// File: tb/tb_eqed_sig_checker.sv
// tb_eqed_sig_checker: directed self-checking bench for eqed_sig_checker
module tb_eqed_sig_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] in_vec = '0;
  logic [2:0] out_vec = '0;
  logic [5:0] exp_in_sig = '0;
  logic [5:0] exp_out_sig = '0;
  logic [5:0] in_sig, out_sig;
  logic busy, done, pass, fail;
  int checks = 0;
  int errors = 0;
`ifdef EQED_SIG_CYCLE_CNT_EN
  logic [15:0] cyc_cnt, done_cyc;
`endif
  eqed_sig_checker dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_vec(in_vec), .out_vec(out_vec),
    .exp_in_sig(exp_in_sig), .exp_out_sig(exp_out_sig),
    .in_sig(in_sig), .out_sig(out_sig),
    .busy(busy), .done(done), .pass(pass), .fail(fail)
`ifdef EQED_SIG_CYCLE_CNT_EN
    , .cyc_cnt(cyc_cnt), .done_cyc(done_cyc)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_in_sig", 32'(in_sig), 0);
    chk("rst_out_sig", 32'(out_sig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail", 32'(fail), 0);
    tick();
    rst = 1'b1;
`ifdef EQED_SIG_CYCLE_CNT_EN
    chk("cyc_rst", 32'(cyc_cnt), 1);
`endif
    tick(3);
    exp_in_sig = 6'b100001;
    exp_out_sig = 6'b100001;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_e0", 32'(busy), 1);
    chk("t1_seed", 32'(in_sig), 6'b000001);
    tick(5);
    chk("t1_nodone_e5", 32'(done), 0);
    chk("t1_busy_e5", 32'(busy), 1);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_busy_drop", 32'(busy), 0);
    chk("t1_in_sig", 32'(in_sig), 6'b100001);
    chk("t1_out_sig", 32'(out_sig), 6'b100001);
`ifdef EQED_SIG_CYCLE_CNT_EN
    chk("done_cyc", 32'(done_cyc), 10);
`endif
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_pass_sticky", 32'(pass), 1);
    chk("t1_sig_hold", 32'(in_sig), 6'b100001);
    in_vec = 2'b01;
    exp_in_sig = 6'b111110;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(6);
    chk("t2_done", 32'(done), 1);
    chk("t2_in_sig", 32'(in_sig), 6'b111110);
    chk("t2_pass", 32'(pass), 1);
    exp_in_sig = 6'b111111;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2b_clear", 32'({pass, fail}), 0);
    tick(6);
    chk("t2b_done", 32'(done), 1);
    chk("t2b_pass", 32'(pass), 0);
    chk("t2b_fail", 32'(fail), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_pf", 32'({pass, fail}), 0);
    for (int i = 0; i < 5; i++) chk("ab_nodone", 32'(done), 0);
    tick(4);
    chk("ab_nodone_late", 32'(done), 0);
    chk("ab_hold", 32'(in_sig), 6'b000111);
    exp_in_sig = 6'b111110;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(6);
    chk("ab_after_done", 32'(done), 1);
    chk("ab_after_pass", 32'(pass), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    start = 1'b1;
    tick();
    chk("st_done_on_time", 32'(done), 1);
    chk("st_pass", 32'(pass), 1);
    chk("st_busy_low", 32'(busy), 0);
    tick();
    start = 1'b0;
    chk("st_accept_busy", 32'(busy), 1);
    chk("st_accept_seed", 32'(in_sig), 6'b000001);
    chk("st_accept_clear", 32'(pass), 0);
    tick(2);
    #2 rst = 1'b0;
    #1;
    chk("ar_in_sig", 32'(in_sig), 0);
    chk("ar_out_sig", 32'(out_sig), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_pf", 32'({done, pass, fail}), 0);
    tick();
    rst = 1'b1;
    tick(8);
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_idle_done", 32'(done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_restart", 32'(busy), 1);
    tick(6);
    chk("ar_restart_done", 32'(done), 1);
    chk("ar_restart_pass", 32'(pass), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eqed_sig_checker.md
# eqed_sig_checker

Signature checker for E-QED capture windows. It compacts a module's input and output response streams into two MISRs over a fixed capture window, then compares both signatures against golden values. It reports pass or fail with a one-cycle done pulse. It sits beside an error-injected design under test and is the receiving end of the MISR compaction used by the E-QED harness.

## Interface
- IN_W, 2: width of compacted input vector (1..SIG_W)
- OUT_W, 3: width of compacted output vector (1..SIG_W)
- SIG_W, 6: MISR/signature width (≥2)
- POLY, 6'b110000: feedback tap mask; fb = XOR-reduce(sig & POLY)
- SEED, 6'b000001: MISR load value on start
- WINDOW, 5: number of MISR updates per capture (1..255)

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  begin capture; honoured only in IDLE
- abort  in  1  return to IDLE from any state; no done
- in_vec  in  IN_W  DUT input bits to compact
- out_vec  in  OUT_W  DUT output bits to compact
- exp_in_sig  in  SIG_W  golden input signature, sampled in COMPARE
- exp_out_sig  in  SIG_W  golden output signature, sampled in COMPARE
- in_sig  out  SIG_W  current input MISR
- out_sig  out  SIG_W  current output MISR
- busy  out  1  high in CAPTURE or COMPARE
- done  out  1  one-cycle pulse when result is valid
- pass  out  1  both signatures matched; sticky until next start
- fail  out  1  at least one signature mismatched; sticky until next start

## Operation
- The FSM has three states: IDLE, CAPTURE and COMPARE. Reset state is IDLE.
- **IDLE:**
  - When start=1 and abort=0, load both MISRs with SEED, clear the window counter, clear pass and fail, and go to CAPTURE.
- **CAPTURE:**
  - Each cycle, update both MISRs: sig ← {sig[SIG_W-2:0], fb} ^ zero-extend(vec).
  - Increment the counter on each update.
  - After the WINDOW-th update, go to COMPARE.
- **COMPARE (one cycle):**
  - pass ← (in_sig==exp_in_sig) && (out_sig==exp_out_sig).
  - fail ← !pass.
  - done ← 1, then go to IDLE.
- MISRs hold their value outside CAPTURE, so the final signatures remain readable after done.
- abort has priority over every other input:
  - In CAPTURE or COMPARE, go to IDLE next edge with no done, pass=fail=0, and MISRs held.
  - In IDLE, abort together with start means start is ignored.
- start in CAPTURE or COMPARE is ignored.
- Counter width is 8 bits; it does not wrap within legal WINDOW.

## Timing
- Reset values: in_sig=out_sig=0, busy=0, done=0, pass=0, fail=0, state IDLE, counter 0.
- Reset asserted mid-capture clears everything asynchronously; no done is produced.
- start sampled at edge E0: MISRs equal SEED and busy=1 after E0.
- Vectors are sampled at edges E1..E_WINDOW.
- COMPARE is evaluated at edge E_(WINDOW+1), so done/pass/fail are visible after it, i.e. WINDOW+1 cycles after the start edge.
- busy drops in the same cycle done is high. A new start is accepted on the cycle after done.
- pass and fail are never both 1.

## Configuration
- EQED_SIG_CYCLE_CNT_EN defined:
  - Adds output cyc_cnt [15:0], a free-running counter reset to 1 that increments every cycle and saturates at 16'hFFFF.
  - Adds output done_cyc [15:0], the cyc_cnt value captured when done pulses (reset 0).
- Undefined: both ports and counters are absent, and all other behaviour is identical.

## Test plan
- Defaults, start, in_vec=0, out_vec=0 for 5 cycles, exp_in_sig=exp_out_sig=6'b100001 -> done one cycle at E6, pass=1, fail=0, in_sig=out_sig=6'b100001.
- in_vec=2'b01 held, out_vec=0, exp_in_sig=6'b111110, exp_out_sig=6'b100001 -> pass=1. Repeat with exp_in_sig=6'b111111 -> fail=1, pass=0.
- abort at E3 of capture -> busy=0 next cycle, no done, pass=fail=0. Following start -> normal completion.
- start pulsed again during CAPTURE and together with done -> ignored, no restart. start at E_done+1 -> accepted.
- rst low mid-capture at E2 -> all outputs 0 immediately; after release, state IDLE.
- EQED_SIG_CYCLE_CNT_EN: rst release, wait 3 cycles, start, window 5 -> done_cyc=cyc_cnt at done edge (10); cyc_cnt saturates at 16'hFFFF after 65535 cycles.
